// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST sequencer.
package mem_bist_pkg;

  localparam int DEF_ADDR_SIZE   = 10;
  localparam int DEF_DATA_SIZE   = 8;
  localparam int DEF_MEMORY_SIZE = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_STROBE = 3'd2,
    ST_R_ADDR   = 3'd3,
    ST_R_CMP    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Test pattern for address k: 2*k, optionally inverted. Callers truncate
  // the result to their data width, which gives {k[DATA_SIZE-2:0], 1'b0}.
  function automatic logic [31:0] pat(input logic [31:0] k, input logic invert);
    logic [31:0] p;
    p = k << 1;
    return invert ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_err_log.sv
// Read-back comparator, saturating mismatch counter and first-failure capture.
module mem_bist_err_log
  import mem_bist_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 cmp_en_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [DATA_SIZE-1:0] exp_i,
  input  logic [DATA_SIZE-1:0] act_i,
  output logic                 mismatch_o,
  output logic [ADDR_SIZE:0]   err_count_o,
  output logic [ADDR_SIZE-1:0] first_err_addr_o
);

  logic [ADDR_SIZE:0]   cnt_q;
  logic [ADDR_SIZE-1:0] first_q;

  assign mismatch_o       = cmp_en_i && (act_i != exp_i);
  assign err_count_o      = cnt_q;
  assign first_err_addr_o = first_q;

  // Count mismatches (saturating) and latch the address of the first one.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q   <= '0;
      first_q <= '0;
    end else if (mismatch_o) begin
      if (cnt_q == '0) first_q <= addr_i;
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST sequencer: fills the RAM with pat(k), reads it back and
// reports pass/fail, mismatch count and first failing address.
// Optional feature macro: MEM_BIST_INVERT_PASS_EN adds a second write/read
// pass with the inverted pattern.
//
// Handshake: start is a request sampled only in IDLE; busy is high while a
// test runs, done pulses for one cycle at the end and pass/err_count/
// first_err_addr hold the result until the next accepted start.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wt,
  output logic                 mem_cs,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE:0]   err_count,
  output logic [ADDR_SIZE-1:0] first_err_addr,
  output state_t               dbg_state
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

  state_t               state_q;
  logic [ADDR_SIZE-1:0] k_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic                 rd_q, wt_q, cs_q;
  logic                 busy_q, done_q, pass_q;

  logic                 inv_w;
  logic [ADDR_SIZE-1:0] k_inc;
  logic [DATA_SIZE-1:0] pat_cur, pat_inc;
  logic                 clr_w, cmp_en_w, mismatch_w;

`ifdef MEM_BIST_INVERT_PASS_EN
  // Selects the inverted pattern during the second write/read pass.
  logic phase_q;
  assign inv_w = phase_q;
`else
  assign inv_w = 1'b0;
`endif

  assign k_inc    = k_q + 1'b1;
  assign pat_cur  = DATA_SIZE'(pat(32'(k_q), inv_w));
  assign pat_inc  = DATA_SIZE'(pat(32'(k_inc), inv_w));
  assign clr_w    = (state_q == ST_IDLE) && start;
  assign cmp_en_w = (state_q == ST_R_CMP);

  mem_bist_err_log #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_err_log (
    .clk              (clk),
    .rst              (rst),
    .clr_i            (clr_w),
    .cmp_en_i         (cmp_en_w),
    .addr_i           (k_q),
    .exp_i            (pat_cur),
    .act_i            (mem_rdata),
    .mismatch_o       (mismatch_w),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

  // Sequencer FSM; every RAM pin is registered and set on entry to a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wt_q    <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef MEM_BIST_INVERT_PASS_EN
      phase_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          rd_q <= 1'b0;
          wt_q <= 1'b0;
          cs_q <= 1'b0;
          if (start) begin
            state_q <= ST_W_SETUP;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= DATA_SIZE'(pat(32'd0, 1'b0));
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
`ifdef MEM_BIST_INVERT_PASS_EN
            phase_q <= 1'b0;
`endif
          end
        end
        ST_W_SETUP: begin
          state_q <= ST_W_STROBE;
          cs_q    <= 1'b1;
          wt_q    <= 1'b1;
        end
        ST_W_STROBE: begin
          wt_q <= 1'b0;
          if (k_q == LAST_ADDR) begin
            state_q <= ST_R_ADDR;
            k_q     <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b1;
          end else begin
            state_q <= ST_W_SETUP;
            cs_q    <= 1'b0;
            k_q     <= k_inc;
            addr_q  <= k_inc;
            wdata_q <= pat_inc;
          end
        end
        ST_R_ADDR: begin
          state_q <= ST_R_CMP;
        end
        ST_R_CMP: begin
          if (k_q != LAST_ADDR) begin
            state_q <= ST_R_ADDR;
            k_q     <= k_inc;
            addr_q  <= k_inc;
          end
`ifdef MEM_BIST_INVERT_PASS_EN
          else if (!phase_q) begin
            state_q <= ST_W_SETUP;
            phase_q <= 1'b1;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= DATA_SIZE'(pat(32'd0, 1'b1));
            rd_q    <= 1'b0;
            cs_q    <= 1'b0;
          end
`endif
          else begin
            // The final compare lands on this edge, so fold it into pass.
            state_q <= ST_DONE;
            rd_q    <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count == '0) && !mismatch_w;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wt    = wt_q;
  assign mem_cs    = cs_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist with a behavioural RAM and fault injection.
`timescale 1ns/1ps
module tb_mem_bist;
  import mem_bist_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int MS    = 1024;
  localparam int LIMIT = 10000;
`ifdef MEM_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wt, mem_cs;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  state_t        dbg_state;

  mem_bist #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEMORY_SIZE(MS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_wt         (mem_wt),
    .mem_cs         (mem_cs),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .dbg_state      (dbg_state)
  );

  // ---------------- RAM model with read-side faults ----------------
  // fault_mode: 0 clean, 1 per-address stuck value, 2 bit 0 stuck at 1
  logic [DW-1:0] ram [0:MS-1];
  int            fault_mode;
  bit            stuck_en  [0:MS-1];
  logic [DW-1:0] stuck_val [0:MS-1];

  function automatic logic [DW-1:0] fault_read(input int mode, input bit en,
                                               input logic [DW-1:0] sv,
                                               input logic [DW-1:0] v);
    case (mode)
      1:       return en ? sv : v;
      2:       return v | 8'h01;
      default: return v;
    endcase
  endfunction

  assign mem_rdata = fault_read(fault_mode, stuck_en[mem_addr], stuck_val[mem_addr], ram[mem_addr]);

  // Write strobe: values are stable for the whole strobe cycle.
  always @(posedge clk) begin
    if (mem_cs && mem_wt) ram[mem_addr] <= mem_wdata;
  end

  // Protocol monitors.
  int done_pulses  = 0;
  int overlap_cnt  = 0;
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (mem_wt && mem_rd) overlap_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pattern straight from the arithmetic definition.
  function automatic logic [DW-1:0] pat_ref(input int k, input int p);
    int v;
    v = (2 * k) % 256;
    if (p != 0) v = 255 - v;
    return DW'(v);
  endfunction

  // Reference result: every location of every pass is compared against what
  // a correct RAM would return through the current fault model.
  task automatic model_expect();
    int errs, first;
    logic [DW-1:0] e;
    errs  = 0;
    first = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int k = 0; k < MS; k++) begin
        e = pat_ref(k, p);
        if (fault_read(fault_mode, stuck_en[k], stuck_val[k], e) != e) begin
          if (errs == 0) first = k;
          errs++;
        end
      end
    end
    if (errs > 2047) errs = 2047;
    exp_q.push_back(32'(4 * MS * NPASS + 1));
    exp_q.push_back(32'(errs == 0));
    exp_q.push_back(32'(errs));
    exp_q.push_back(32'(first));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_faults();
    for (int i = 0; i < MS; i++) begin
      stuck_en[i]  = 1'b0;
      stuck_val[i] = '0;
    end
  endtask

  task automatic check_idle(input string name);
    check_eq({name, "_addr"},   32'(mem_addr), 0);
    check_eq({name, "_strobe"}, 32'({mem_cs, mem_rd, mem_wt}), 0);
    check_eq({name, "_wdata"},  32'(mem_wdata), 0);
    check_eq({name, "_busy"},   32'(busy), 0);
    check_eq({name, "_done"},   32'(done), 0);
    check_eq({name, "_pass"},   32'(pass), 0);
    check_eq({name, "_errcnt"}, 32'(err_count), 0);
    check_eq({name, "_first"},  32'(first_err_addr), 0);
    check_eq({name, "_state"},  32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Pulse start at edge 0 and follow the run until done or the cycle budget.
  // restart_at: cycle during which start is raised again (ignored by DUT).
  task automatic run_and_check(input string name, input int restart_at);
    int e, dcyc, pulses0;
    logic [31:0] x_cyc, x_pass, x_errs, x_first;
    model_expect();
    pulses0 = done_pulses;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e    = 0;
    dcyc = -1;
    while (e < LIMIT) begin
      @(negedge clk);
      if (done) begin
        dcyc = e + 1;
        break;
      end
      start = (e + 1 == restart_at);
      if (e + 1 == 50) check_eq({name, "_busy_mid"}, 32'(busy), 1);
      @(posedge clk);
      e++;
    end
    start   = 1'b0;
    x_cyc   = exp_q.pop_front();
    x_pass  = exp_q.pop_front();
    x_errs  = exp_q.pop_front();
    x_first = exp_q.pop_front();
    check_eq({name, "_done_cycle"}, 32'(dcyc), x_cyc);
    check_eq({name, "_pass"},       32'(pass), x_pass);
    check_eq({name, "_errcnt"},     32'(err_count), x_errs);
    if (x_errs != 0) check_eq({name, "_first"}, 32'(first_err_addr), x_first);
    repeat (3) @(negedge clk);
    check_eq({name, "_one_done"},  32'(done_pulses - pulses0), 1);
    check_eq({name, "_busy_end"},  32'(busy), 0);
    check_eq({name, "_pass_held"}, 32'(pass), x_pass);
    check_eq({name, "_idle"},      32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Start a run, then assert reset either in W_STROBE at at_addr or during
  // cycle at_cycle (when at_addr < 0); all outputs must clear on that edge.
  task automatic reset_when(input string name, input int at_cycle, input int at_addr);
    int e;
    bit hit;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e   = 0;
    hit = 1'b0;
    while (e < LIMIT) begin
      @(negedge clk);
      if (at_addr >= 0) hit = mem_wt && (int'(mem_addr) == at_addr);
      else              hit = (e + 1 == at_cycle);
      if (hit) break;
      @(posedge clk);
      e++;
    end
    check_eq({name, "_reached"}, 32'(hit), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle(name);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq({name, "_stay_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a, n;
    rst        = 1'b1;
    start      = 1'b0;
    fault_mode = 0;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_idle("por");
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a write strobe.
    reset_when("rst_w300", 0, 300);

    // Clean RAM, with a start re-assertion while busy.
    run_and_check("clean", 100);
    check_eq("ram_200", 32'(ram[200]), 32'(pat_ref(200, NPASS - 1)));
    check_eq("ram_127", 32'(ram[127]), 32'(pat_ref(127, NPASS - 1)));
    check_eq("ram_5",   32'(ram[5]),   32'(pat_ref(5, NPASS - 1)));
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, MS - 1);
      check_eq("ram_rand", 32'(ram[a]), 32'(pat_ref(a, NPASS - 1)));
    end

    // Location 513 stuck at zero.
    fault_mode     = 1;
    stuck_en[513]  = 1'b1;
    stuck_val[513] = 8'h00;
    run_and_check("stuck513", 0);

    // Bit 0 stuck at one everywhere.
    fault_mode = 2;
    clear_faults();
    run_and_check("bit0", 0);

    // Random stuck locations with random values and random spurious starts.
    for (int r = 0; r < 2; r++) begin
      fault_mode = 1;
      clear_faults();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        a = $urandom_range(0, MS - 1);
        stuck_en[a]  = 1'b1;
        stuck_val[a] = DW'($urandom_range(0, 255));
      end
      run_and_check("rand_stuck", $urandom_range(2, 4000));
    end

    // Reset during the read phase while errors are being logged.
    fault_mode = 2;
    clear_faults();
    reset_when("rst_rand", $urandom_range(2100, 4000), -1);

    // Recovery after reset.
    fault_mode = 0;
    run_and_check("recover", 0);

    check_eq("wt_rd_overlap", 32'(overlap_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
